// File: rtl/keypad_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | keypad_pkg : shared types and width helpers for keypad_scan_ctrl      |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EVAL  = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_t;

  // Never return zero so single-entry counters still get a 1-bit vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return clog2_min1(rows * cols);
  endfunction

  function automatic int div_width(input int scan_div);
    return clog2_min1(scan_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bus.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_bus : WIDTH-bit 2-flop synchronizer, resets to all ones (idle    |
// |            level of active-low pulled-up inputs)                      |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module sync_bus #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | keypad_scan_ctrl : row-scanning matrix keypad controller with frame   |
// |                    debounce. Optional auto-repeat: KEYPAD_REPEAT_EN   |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_FRAMES = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [COLS-1:0]                   col_in,
  output logic [ROWS-1:0]                   row_out,
  output logic [code_width(ROWS, COLS)-1:0] key_code,
  output logic                              key_valid,
  output logic                              key_held,
  output logic                              multi_key
);

  localparam int c_KW = code_width(ROWS, COLS);
  localparam int c_DW = div_width(SCAN_DIV);
  localparam int c_RW = clog2_min1(ROWS);
  localparam int c_CW = clog2_min1(COLS);
  localparam int c_SW = clog2_min1(DEBOUNCE + 1);
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(SCAN_DIV - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(ROWS - 1);
  localparam logic [c_SW-1:0] c_DEB      = c_SW'(DEBOUNCE);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("DEBOUNCE must be >= 1");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("REPEAT_FRAMES must be >= 1");
  end

  logic [COLS-1:0] w_cols;

  sync_bus #(.WIDTH(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (w_cols)
  );

  scan_state_t      r_state, w_state_nxt;
  frame_class_t     w_class;
  logic [c_RW-1:0]  r_row;
  logic [c_DW-1:0]  r_div;
  logic [1:0]       r_hits, w_row_hits, w_hits_acc;
  logic [2:0]       w_hits_sum;
  logic [c_CW-1:0]  w_row_col;
  logic [c_KW-1:0]  w_row_key, r_frame_key, r_cand, r_code;
  logic [c_SW-1:0]  r_stable, r_release, w_stab_inc, w_rel_inc;
  logic             r_valid, r_held, r_multi, w_sample;
`ifdef KEYPAD_REPEAT_EN
  localparam int c_PW = clog2_min1(REPEAT_FRAMES + 1);
  localparam logic [c_PW-1:0] c_REP_LAST = c_PW'(REPEAT_FRAMES - 1);
  logic [c_PW-1:0]  r_rep;
`endif

  assign w_sample = (r_state == DRIVE) && (r_div == c_DIV_LAST);

  // Press count per row saturates at 2: only none/single/multi matter.
  always_comb begin
    w_row_hits = 2'd0;
    w_row_col  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!w_cols[c]) begin
        if (w_row_hits == 2'd0) w_row_col = c_CW'(c);
        w_row_hits = (w_row_hits == 2'd0) ? 2'd1 : 2'd2;
      end
    end
  end

  assign w_row_key  = c_KW'(int'(r_row) * COLS + int'(w_row_col));
  assign w_hits_sum = {1'b0, r_hits} + {1'b0, w_row_hits};
  assign w_hits_acc = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];

  always_comb begin
    w_class    = (r_hits == 2'd0) ? NONE : ((r_hits == 2'd1) ? SINGLE : MULTI);
    w_stab_inc = c_SW'(1);
    if (r_frame_key == r_cand) w_stab_inc = (r_stable == c_DEB) ? c_DEB : r_stable + 1'b1;
    w_rel_inc  = (r_release == c_DEB) ? c_DEB : r_release + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = DRIVE;
      DRIVE:   if (!en) w_state_nxt = IDLE;
               else if (w_sample && r_row == c_ROW_LAST) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = en ? DRIVE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0; r_div <= '0; r_hits <= '0; r_frame_key <= '0;
      r_cand <= '0; r_stable <= '0; r_release <= '0; r_code <= '0;
      r_valid <= 1'b0; r_held <= 1'b0; r_multi <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        // Disabling abandons the frame and any debounce progress; key_code is kept.
        r_row <= '0; r_div <= '0; r_hits <= '0; r_frame_key <= '0;
        r_cand <= '0; r_stable <= '0; r_release <= '0;
        r_held <= 1'b0; r_multi <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
        r_rep <= '0;
`endif
      end else if (r_state == DRIVE) begin
        if (w_sample) begin
          r_div  <= '0;
          r_row  <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
          r_hits <= w_hits_acc;
          if (r_hits == 2'd0 && w_row_hits == 2'd1) r_frame_key <= w_row_key;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end else if (r_state == EVAL) begin
        r_hits  <= '0;
        r_multi <= (w_class == MULTI);
        case (w_class)
          NONE: begin
            r_stable  <= '0;
            r_release <= w_rel_inc;
            if (w_rel_inc == c_DEB) r_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep <= '0;
`endif
          end
          SINGLE: begin
            r_release <= '0;
            r_cand    <= r_frame_key;
            r_stable  <= w_stab_inc;
            if (w_stab_inc == c_DEB && !r_held) begin
              r_code  <= r_frame_key;
              r_held  <= 1'b1;
              r_valid <= 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            if (r_held && r_frame_key == r_code) begin
              if (r_rep == c_REP_LAST) begin
                r_rep   <= '0;
                r_valid <= 1'b1;
              end else begin
                r_rep <= r_rep + 1'b1;
              end
            end else begin
              r_rep <= '0;
            end
`endif
          end
          default: begin
            r_stable  <= '0;
            r_release <= '0;
`ifdef KEYPAD_REPEAT_EN
            r_rep <= '0;
`endif
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_out[r] = !((r_state == DRIVE) && (r_row == c_RW'(r)));
    end
  end

  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign multi_key = r_multi;

endmodule
`default_nettype wire
